// File: rtl/fetch_queue_pkg.sv
// Shared CPU constants and the fetch-queue entry layout.
// Also provides the address-error test used when FQ_ADEL_CHECK_EN is defined.
package fetch_queue_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] IM_LO    = 32'h0000_3000;
  localparam logic [31:0] IM_HI    = 32'h0000_6FFF;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [4:0]  EXC_NONE = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        bd;
    logic [4:0]  exc_code;
  } fq_entry_t;

  localparam int ENTRY_W = $bits(fq_entry_t);

  // A fetch faults when misaligned or outside the instruction memory window.
  function automatic logic is_adel(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for fetch_queue: one synchronous write port and one asynchronous read port.
// Contents are not reset; the control logic never exposes an unwritten slot.
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  fq_entry_t       wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output fq_entry_t       rdata_o
);

  fq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between PCreg/IM and decode; head entry drives D_* combinationally.
// Optional macro FQ_ADEL_CHECK_EN tags misaligned or out-of-window PCs with AdEL at push.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] F_PC_i,
  input  logic [31:0] F_Instr_i,
  input  logic        F_BD_i,
  input  logic        F_valid_i,
  output logic        F_ready_o,
  input  logic        D_stall_i,
  input  logic        flush_i,
  output logic [31:0] D_PC_o,
  output logic [31:0] D_Instr_o,
  output logic        D_BD_o,
  output logic [4:0]  D_ExcCode_o,
  output logic        D_valid_o
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic          push, pop;
  fq_entry_t     wr_entry, head;

  assign F_ready_o = (count_q < DEPTH_C);
  assign D_valid_o = (count_q != '0);
  assign push      = F_valid_i && F_ready_o && !flush_i;
  assign pop       = D_valid_o && !D_stall_i && !flush_i;

  always_comb begin
    wr_entry.pc       = F_PC_i;
    wr_entry.bd       = F_BD_i;
    wr_entry.instr    = F_Instr_i;
    wr_entry.exc_code = EXC_NONE;
`ifdef FQ_ADEL_CHECK_EN
    if (is_adel(F_PC_i)) begin
      wr_entry.instr    = NOP_WORD;
      wr_entry.exc_code = EXC_ADEL;
    end
`endif
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    count_d = count_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    if (flush_i) begin
      count_d = '0;
      rptr_d  = '0;
      wptr_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
    end else begin
      count_q <= count_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rptr_q),
    .rdata_o (head)
  );

  // An empty queue presents a NOP so stale storage never leaks to decode.
  always_comb begin
    D_PC_o      = '0;
    D_Instr_o   = NOP_WORD;
    D_BD_o      = 1'b0;
    D_ExcCode_o = EXC_NONE;
    if (D_valid_o) begin
      D_PC_o      = head.pc;
      D_Instr_o   = head.instr;
      D_BD_o      = head.bd;
      D_ExcCode_o = head.exc_code;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4): vector table plus corner sequences.
// Expected AdEL behaviour follows FQ_ADEL_CHECK_EN when the bench is built with it.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic [31:0] F_PC_i;
  logic [31:0] F_Instr_i;
  logic        F_BD_i;
  logic        F_valid_i;
  logic        F_ready_o;
  logic        D_stall_i;
  logic        flush_i;
  logic [31:0] D_PC_o;
  logic [31:0] D_Instr_o;
  logic        D_BD_o;
  logic [4:0]  D_ExcCode_o;
  logic        D_valid_o;

  int testsRun    = 0;
  int testsFailed = 0;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .F_PC_i      (F_PC_i),
    .F_Instr_i   (F_Instr_i),
    .F_BD_i      (F_BD_i),
    .F_valid_i   (F_valid_i),
    .F_ready_o   (F_ready_o),
    .D_stall_i   (D_stall_i),
    .flush_i     (flush_i),
    .D_PC_o      (D_PC_o),
    .D_Instr_o   (D_Instr_o),
    .D_BD_o      (D_BD_o),
    .D_ExcCode_o (D_ExcCode_o),
    .D_valid_o   (D_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        fvalid;
    logic        stall;
    logic [31:0] pc;
    logic        bd;
    logic        expReady;
    logic        expValid;
    logic [31:0] expPc;
    logic        expBd;
  } vec_t;

  function automatic logic [31:0] imWord(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  function automatic logic expAdel(input logic [31:0] pc);
`ifdef FQ_ADEL_CHECK_EN
    return (pc[1:0] != 2'b00) || (pc < 32'h3000) || (pc > 32'h6FFF);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] expInstr(input logic [31:0] pc);
    return expAdel(pc) ? 32'h0 : imWord(pc);
  endfunction

  function automatic logic [4:0] expExc(input logic [31:0] pc);
    return expAdel(pc) ? 5'd4 : 5'd0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, then sample 1ns after the edge.
  task automatic applyStimulus(input logic flush, input logic fvalid, input logic stall,
                               input logic [31:0] pc, input logic bd);
    flush_i   = flush;
    F_valid_i = fvalid;
    D_stall_i = stall;
    F_PC_i    = pc;
    F_Instr_i = imWord(pc);
    F_BD_i    = bd;
    @(posedge clk);
    #1;
  endtask

  task automatic checkHead(input string tag, input logic expReady, input logic expValid,
                           input logic [31:0] expPc, input logic expBd);
    checkOutput({tag, ".ready"}, 32'(F_ready_o), 32'(expReady));
    checkOutput({tag, ".valid"}, 32'(D_valid_o), 32'(expValid));
    checkOutput({tag, ".pc"},    D_PC_o, expValid ? expPc : 32'h0);
    checkOutput({tag, ".instr"}, D_Instr_o, expValid ? expInstr(expPc) : 32'h0);
    checkOutput({tag, ".bd"},    32'(D_BD_o), expValid ? 32'(expBd) : 32'h0);
    checkOutput({tag, ".exc"},   32'(D_ExcCode_o), expValid ? 32'(expExc(expPc)) : 32'h0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    reset = 1'b0;
  endtask

  vec_t vecs[17];
  logic [31:0] modelQ[$];
  logic [31:0] nextPc;
  logic [31:0] lastPopped;

  initial begin
    reset = 1'b1;
    flush_i = 1'b0; F_valid_i = 1'b0; D_stall_i = 1'b1;
    F_PC_i = '0; F_Instr_i = '0; F_BD_i = 1'b0;

    //            flush fvalid stall pc          bd  rdy vld expPc       expBd
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 32'h3000, 1'b0, 1'b1, 1'b1, 32'h3000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h3004, 1'b0, 1'b1, 1'b1, 32'h3000, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h3008, 1'b0, 1'b1, 1'b1, 32'h3000, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h300C, 1'b0, 1'b0, 1'b1, 32'h3000, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h3010, 1'b0, 1'b0, 1'b1, 32'h3000, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 32'h3004, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 32'h3008, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 32'h300C, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 32'h0,    1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h3020, 1'b0, 1'b1, 1'b1, 32'h3020, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 32'h3024, 1'b0, 1'b1, 1'b1, 32'h3020, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h3028, 1'b0, 1'b1, 1'b1, 32'h3024, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 32'h302C, 1'b0, 1'b1, 1'b1, 32'h3024, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 32'h3030, 1'b0, 1'b1, 1'b0, 32'h0,    1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 32'h0,    1'b0, 1'b1, 1'b0, 32'h0,    1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 32'h3040, 1'b1, 1'b1, 1'b1, 32'h3040, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 32'h0,    1'b0};

    doReset();
    checkHead("reset", 1'b1, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].flush, vecs[i].fvalid, vecs[i].stall, vecs[i].pc, vecs[i].bd);
      checkHead($sformatf("vec%0d", i), vecs[i].expReady, vecs[i].expValid,
                vecs[i].expPc, vecs[i].expBd);
    end

    // Reset wins over a concurrent push and flush.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h3100, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h3104, 1'b0);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h3108, 1'b0);
    reset = 1'b0;
    checkHead("rstPri", 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    checkHead("rstPriIdle", 1'b1, 1'b0, 32'h0, 1'b0);

    // Streaming across several pointer wraps with a queue model as scoreboard.
    modelQ.delete();
    nextPc = 32'h3200;
    lastPopped = 32'h0;
    for (int c = 0; c < 3 * DEPTH + 4; c++) begin
      logic doPush, doPop, stall;
      stall  = (c % 5 == 2);
      doPush = (c < 3 * DEPTH) && (modelQ.size() < DEPTH);
      doPop  = (modelQ.size() > 0) && !stall;
      applyStimulus(1'b0, c < 3 * DEPTH, stall, nextPc, 1'b0);
      if (doPop) begin
        lastPopped = modelQ.pop_front();
      end
      if (doPush) begin
        modelQ.push_back(nextPc);
        nextPc = nextPc + 32'd4;
      end else if (c < 3 * DEPTH) begin
        nextPc = nextPc;
      end
      checkHead($sformatf("wrap%0d", c), modelQ.size() < DEPTH, modelQ.size() > 0,
                (modelQ.size() > 0) ? modelQ[0] : 32'h0, 1'b0);
    end
    checkOutput("wrapLastPc", lastPopped, nextPc - 32'd4);

    // Address-error tagging at push, then drain in order.
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h3002, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h7000, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h6FFC, 1'b0);
    checkHead("adel0", 1'b1, 1'b1, 32'h3002, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkHead("adel1", 1'b1, 1'b1, 32'h7000, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkHead("adel2", 1'b1, 1'b1, 32'h6FFC, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkHead("adelEmpty", 1'b1, 1'b0, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two, 2..16.
REQ-002 Port clk, input, 1, rising-edge clock for all state.
REQ-003 Port reset, input, 1, synchronous active-high reset.
REQ-004 Port F_PC_i, input, 32, PC of the fetched instruction (from PCreg).
REQ-005 Port F_Instr_i, input, 32, instruction word read from IM at F_PC_i.
REQ-006 Port F_BD_i, input, 1, fetched instruction is in a branch delay slot.
REQ-007 Port F_valid_i, input, 1, fetch presents a new instruction this cycle.
REQ-008 Port F_ready_o, output, 1, queue can accept a push; the inverse drives the PCreg stall input.
REQ-009 Port D_stall_i, input, 1, decode cannot consume this cycle.
REQ-010 Port flush_i, input, 1, discard all queued instructions (branch redirect/exception).
REQ-011 Ports D_PC_o (32), D_Instr_o (32), D_BD_o (1), D_ExcCode_o (5), D_valid_o (1), outputs, head entry presented to decode.

Function
REQ-012 Push SHALL occur on a rising edge when F_valid_i=1, F_ready_o=1 and flush_i=0.
REQ-013 Pop SHALL occur on a rising edge when D_valid_o=1, D_stall_i=0 and flush_i=0.
REQ-014 F_ready_o SHALL be 1 exactly when count < DEPTH; it depends on count only, so there is no push when full, even with a simultaneous pop.
REQ-015 D_valid_o SHALL be 1 exactly when count > 0; the outputs SHALL be driven combinationally from the head entry.
REQ-016 Latency SHALL be one cycle: an entry pushed at edge N is visible on D_* after edge N. There is no bypass when empty.
REQ-017 When empty, D_PC_o, D_Instr_o, D_BD_o and D_ExcCode_o SHALL all be 0 (NOP).
REQ-018 When push and pop occur on the same edge, count SHALL be unchanged and both pointers SHALL advance.
REQ-019 Read and write pointers SHALL wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits and never exceed DEPTH or go below 0.
REQ-020 flush_i=1 SHALL take priority over push and pop: on that edge count and both pointers go to 0, and any concurrent push is discarded.
REQ-021 Entries SHALL preserve FIFO order of PC, Instr, BD and ExcCode together. No field SHALL be reordered or split.

Reset
REQ-022 When reset=1 at an edge, count, read pointer and write pointer SHALL be 0. Reset overrides flush, push and pop.
REQ-023 After reset, F_ready_o=1, D_valid_o=0, and all D_* data outputs are 0.
REQ-024 Storage contents need not be reset; they SHALL never be visible while count=0.

Configuration
REQ-025 Macro FQ_ADEL_CHECK_EN, when defined, enables an address-error check at push.
  - Trigger: F_PC_i[1:0]!=0, or F_PC_i outside 0x0000_3000..0x0000_6FFF.
  - Stored entry: ExcCode=5'd4 (AdEL) and Instr=0; PC and BD are stored unchanged.
REQ-026 Without FQ_ADEL_CHECK_EN, ExcCode SHALL always be stored as 0 and Instr stored unmodified.

Structure
REQ-027 The shared CPU package SHALL hold:
  - reset PC 32'h3000;
  - IM bounds 0x3000/0x6FFF;
  - NOP word 32'h0;
  - ExcCode constant EXC_ADEL=5'd4.
REQ-028 Storage SHALL be one sub-module, fetch_queue_mem: DEPTH x 70-bit register array, one synchronous write port, one asynchronous read port. Pointer, count and control logic stay in fetch_queue.

Verification
REQ-029 Reset, then push PC 0x3000/0x3004/0x3008 with D_stall_i=1 -> count 3; D_PC_o=0x3000 from the edge after the first push; F_ready_o=1.
REQ-030 With DEPTH=4, push 5 times with D_stall_i=1 -> F_ready_o=0 after the 4th push; the 5th is not accepted; drain order is 0x3000, 0x3004, 0x3008, 0x300C.
REQ-031 Queue at count 2, assert F_valid_i and pop on the same edge -> count stays 2; the head advances by one entry.
REQ-032 Queue at count 3, flush_i=1 with F_valid_i=1 -> next cycle D_valid_o=0, D_Instr_o=0, F_ready_o=1; the concurrent push is lost.
REQ-033 Push more than 2*DEPTH entries with continuous pops -> output PC order is monotonic across pointer wrap; there is no duplicate or lost entry.
REQ-034 With FQ_ADEL_CHECK_EN, push PC 0x3002 and then 0x7000 -> both pop with D_ExcCode_o=4 and D_Instr_o=0. Without the macro -> ExcCode=0 and Instr is the IM word.
